gfx256_zbuf_test: RTL and testbench
===================================

GFX256_ZBUF_TEST -- requirements
Module: gfx256_zbuf_test

Interface
REQ-001 SHALL have parameter point_width, default 16, pixel coordinate and depth width.
REQ-002 SHALL have ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- write_i  in  1  upstream fragment valid, level, held until ack_o.
- ack_o  out  1  one-cycle pulse, fragment consumed.
- x_i, y_i  in  point_width  fragment position.
- z_i  in  point_width  signed interpolated depth.
- color_i  in  32  packed color.
- a_i  in  8  alpha.
- zbuf_enable_i  in  1  depth test enabled.
- zbuf_base_i  in  32  depth buffer byte base address.
- target_width_i  in  point_width  pixels per row.
- mem_cyc_o, mem_stb_o, mem_we_o  out  1  depth memory bus controls.
- mem_adr_o  out  32  byte address.
- mem_sel_o  out  4  byte lane select.
- mem_dat_o  out  32  write data.
- mem_dat_i  in  32  read data.
- mem_ack_i  in  1  memory acknowledge.
- write_o  out  1  downstream pixel valid, held until ack_i.
- ack_i  in  1  downstream acknowledge.
- x_o, y_o  out  point_width  passed position.
- color_o  out  32  passed color.
- a_o  out  8  passed alpha.

Function
REQ-003 SHALL use states IDLE, ZREAD, ZWRITE, PIXOUT, DONE.
REQ-004 IDLE SHALL accept write_i only while ack_o is low, latching x, y, z, color and alpha on that edge.
REQ-005 On accept, the next state SHALL be ZREAD if zbuf_enable_i=1, else PIXOUT.
REQ-006 Depth address SHALL be zbuf_base_i + 2*(y*target_width_i + x), computed with 32-bit wrap-around.
REQ-007 Lane select SHALL be 4'b0011 when address bit 1 = 0, else 4'b1100.
REQ-008 ZREAD SHALL hold cyc=1, stb=1, we=0 until mem_ack_i.
REQ-009 On mem_ack_i, ZREAD SHALL extract the selected 16-bit half as a signed stored depth.
REQ-010 Depth test SHALL pass when signed z > stored depth; equal depth fails.
REQ-011 On fail, ZREAD SHALL go to DONE with no write_o.
REQ-012 On pass, ZREAD SHALL go to ZWRITE (macro defined) or PIXOUT (macro undefined).
REQ-013 ZWRITE SHALL hold cyc=1, stb=1, we=1 with the same address and sel, and z replicated in both halves of mem_dat_o, until mem_ack_i, then go to PIXOUT.
REQ-014 cyc and stb SHALL drop on the edge following mem_ack_i; no bus cycle SHALL be issued outside ZREAD and ZWRITE.
REQ-015 PIXOUT SHALL assert write_o with the latched x, y, color and alpha until ack_i, then deassert write_o and go to DONE.
REQ-016 DONE SHALL pulse ack_o for exactly one cycle, then return to IDLE.
REQ-017 zbuf_enable_i, zbuf_base_i and target_width_i SHALL be sampled only at accept.
REQ-018 A mem_ack_i or ack_i outside its wait state SHALL be ignored.
REQ-019 Minimum latency with the test disabled SHALL be accept to write_o in 1 cycle.

Reset
REQ-020 rst_i SHALL immediately force state IDLE and drive all outputs to 0, including mid-bus-cycle, abandoning the fragment.
REQ-021 After reset release, the first accept SHALL occur no earlier than the first clock edge with write_i=1.

Configuration
REQ-022 With GFX256_ZBUF_UPDATE_EN defined, passing fragments SHALL write their depth in ZWRITE.
REQ-023 With GFX256_ZBUF_UPDATE_EN undefined, ZWRITE SHALL be absent, mem_we_o SHALL be tied 0, and the depth buffer SHALL be read-only (test only).

Verification
REQ-024 Bench SHALL cover: zbuf_enable_i=0, x=3, y=2 -> no bus cycle; write_o with x_o=3, y_o=2 one cycle after accept; one ack_o pulse after ack_i.
REQ-025 Bench SHALL cover: base=0x1000, width=640, x=1, y=1, stored depth 0x0010, z=0x0020, macro on -> read at adr 0x1502, sel 4'b1100; write 0x00200020; write_o asserted.
REQ-026 Bench SHALL cover: stored depth 0x0020, z=0x0020 -> fails; no write_o; ack_o pulse.
REQ-027 Bench SHALL cover: stored depth 0xFFF0 (-16), z=0x0001 -> passes under the signed comparison.
REQ-028 Bench SHALL cover: rst_i asserted during ZREAD wait -> cyc=stb=0 immediately; no ack_o; the next fragment is processed normally.
REQ-029 Bench SHALL cover: write_i held high through the ack_o pulse -> only one fragment accepted.

Source files
------------

// File: rtl/gfx256_zbuf_test.sv
// gfx256_zbuf_test -- depth-buffer test stage of the gfx256 fragment pipeline.
//
// Takes one fragment at a time from upstream. If the depth test is enabled,
// the 16-bit stored depth is read from the depth buffer and compared (signed)
// against the fragment depth. The fragment is dropped when its depth is not
// strictly greater. When it passes, it can optionally write its depth back
// and is then forwarded downstream. Each fragment is retired with a single
// ack_o pulse.
//
// Optional feature macro: GFX256_ZBUF_UPDATE_EN
//   defined   : passing fragments write their depth back (ZWRITE state).
//   undefined : the depth buffer is read-only and mem_we_o is tied low.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   write_i / ack_o         upstream fragment valid (level) / consumed pulse
//   x_i, y_i, z_i           fragment position and signed depth
//   color_i, a_i            packed colour and alpha
//   zbuf_enable_i           depth test enable (sampled at accept)
//   zbuf_base_i             depth buffer byte base address (sampled at accept)
//   target_width_i          pixels per row (sampled at accept)
//   mem_*                   depth memory bus (cyc/stb/we/adr/sel/dat, ack)
//   write_o / ack_i         downstream pixel valid (held) / acknowledge
//   x_o, y_o, color_o, a_o  forwarded fragment attributes
module gfx256_zbuf_test #(
  parameter int point_width = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   write_i,
  output logic                   ack_o,
  input  logic [point_width-1:0] x_i,
  input  logic [point_width-1:0] y_i,
  input  logic [point_width-1:0] z_i,
  input  logic [31:0]            color_i,
  input  logic [7:0]             a_i,
  input  logic                   zbuf_enable_i,
  input  logic [31:0]            zbuf_base_i,
  input  logic [point_width-1:0] target_width_i,
  output logic                   mem_cyc_o,
  output logic                   mem_stb_o,
  output logic                   mem_we_o,
  output logic [31:0]            mem_adr_o,
  output logic [3:0]             mem_sel_o,
  output logic [31:0]            mem_dat_o,
  input  logic [31:0]            mem_dat_i,
  input  logic                   mem_ack_i,
  output logic                   write_o,
  input  logic                   ack_i,
  output logic [point_width-1:0] x_o,
  output logic [point_width-1:0] y_o,
  output logic [31:0]            color_o,
  output logic [7:0]             a_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ZREAD  = 3'd1,
    PIXOUT = 3'd2,
    DONE   = 3'd3
`ifdef GFX256_ZBUF_UPDATE_EN
    ,
    ZWRITE = 3'd4
`endif
  } t_state;

  t_state                   r_state;
  t_state                   w_state_next;
  logic [point_width-1:0]   r_x;
  logic [point_width-1:0]   r_y;
  logic [point_width-1:0]   r_z;
  logic [31:0]              r_color;
  logic [7:0]               r_a;
  logic [31:0]              r_adr;

  logic                     w_accept;
  logic [31:0]              w_lin;
  logic [31:0]              w_adr_calc;
  logic [15:0]              w_stored;
  logic signed [31:0]       w_z_ext;
  logic signed [31:0]       w_stored_ext;
  logic                     w_pass;
  logic                     w_bus;
  logic [3:0]               w_sel;

  // ack_o is only ever high in DONE, so the "ack_o low" qualifier is kept
  // for clarity of the handshake rather than out of necessity.
  assign w_accept = (r_state == IDLE) && write_i && !ack_o;

  // Pixel index and byte address, all arithmetic wrapping at 32 bits.
  assign w_lin      = 32'(y_i) * 32'(target_width_i) + 32'(x_i);
  assign w_adr_calc = zbuf_base_i + {w_lin[30:0], 1'b0};

  // Address bit 1 picks which 16-bit half of the 32-bit word holds our depth.
  assign w_sel        = r_adr[1] ? 4'b1100 : 4'b0011;
  assign w_stored     = r_adr[1] ? mem_dat_i[31:16] : mem_dat_i[15:0];
  assign w_z_ext      = 32'($signed(r_z));
  assign w_stored_ext = 32'($signed(w_stored));
  assign w_pass       = w_z_ext > w_stored_ext;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_color <= '0;
      r_a     <= '0;
      r_adr   <= '0;
    end else if (w_accept) begin
      r_x     <= x_i;
      r_y     <= y_i;
      r_z     <= z_i;
      r_color <= color_i;
      r_a     <= a_i;
      r_adr   <= w_adr_calc;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = zbuf_enable_i ? ZREAD : PIXOUT;
        end
      end
      ZREAD: begin
        if (mem_ack_i) begin
`ifdef GFX256_ZBUF_UPDATE_EN
          w_state_next = w_pass ? ZWRITE : DONE;
`else
          w_state_next = w_pass ? PIXOUT : DONE;
`endif
        end
      end
`ifdef GFX256_ZBUF_UPDATE_EN
      ZWRITE: begin
        if (mem_ack_i) begin
          w_state_next = PIXOUT;
        end
      end
`endif
      PIXOUT: begin
        if (ack_i) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // All handshake and bus outputs decode straight from the state register so
  // that the asynchronous reset clears them immediately.
`ifdef GFX256_ZBUF_UPDATE_EN
  assign w_bus     = (r_state == ZREAD) || (r_state == ZWRITE);
  assign mem_we_o  = (r_state == ZWRITE);
  assign mem_dat_o = (r_state == ZWRITE) ? {r_z[15:0], r_z[15:0]} : 32'd0;
`else
  assign w_bus     = (r_state == ZREAD);
  assign mem_we_o  = 1'b0;
  assign mem_dat_o = 32'd0;
`endif

  assign mem_cyc_o = w_bus;
  assign mem_stb_o = w_bus;
  assign mem_adr_o = w_bus ? r_adr : 32'd0;
  assign mem_sel_o = w_bus ? w_sel : 4'd0;

  assign write_o = (r_state == PIXOUT);
  assign ack_o   = (r_state == DONE);
  assign x_o     = r_x;
  assign y_o     = r_y;
  assign color_o = r_color;
  assign a_o     = r_a;

endmodule

// File: tb/tb_gfx256_zbuf_test.sv
module tb_gfx256_zbuf_test;

  localparam int PW = 16;
`ifdef GFX256_ZBUF_UPDATE_EN
  localparam bit UPD = 1'b1;
`else
  localparam bit UPD = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          write_i;
  logic          ack_o;
  logic [PW-1:0] x_i, y_i, z_i;
  logic [31:0]   color_i;
  logic [7:0]    a_i;
  logic          zbuf_enable_i;
  logic [31:0]   zbuf_base_i;
  logic [PW-1:0] target_width_i;
  logic          mem_cyc_o, mem_stb_o, mem_we_o;
  logic [31:0]   mem_adr_o;
  logic [3:0]    mem_sel_o;
  logic [31:0]   mem_dat_o;
  logic [31:0]   mem_dat_i;
  logic          mem_ack_i;
  logic          write_o;
  logic          ack_i;
  logic [PW-1:0] x_o, y_o;
  logic [31:0]   color_o;
  logic [7:0]    a_o;

  always #5 clk_i = ~clk_i;

  gfx256_zbuf_test #(.point_width(PW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .write_i(write_i), .ack_o(ack_o),
    .x_i(x_i), .y_i(y_i), .z_i(z_i), .color_i(color_i), .a_i(a_i),
    .zbuf_enable_i(zbuf_enable_i), .zbuf_base_i(zbuf_base_i),
    .target_width_i(target_width_i),
    .mem_cyc_o(mem_cyc_o), .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o),
    .mem_adr_o(mem_adr_o), .mem_sel_o(mem_sel_o), .mem_dat_o(mem_dat_o),
    .mem_dat_i(mem_dat_i), .mem_ack_i(mem_ack_i),
    .write_o(write_o), .ack_i(ack_i),
    .x_o(x_o), .y_o(y_o), .color_o(color_o), .a_o(a_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Depth memory seen by the DUT, one 32-bit word per key (byte address >> 2).
  logic [31:0] mem [int unsigned];

  task automatic run_frag(input bit en, input logic [31:0] base, input logic [15:0] w,
                          input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                          input logic [15:0] stored, input logic [31:0] col, input logic [7:0] a);
    longint       lin;
    longint       base_l;
    logic [31:0]  exp_adr;
    logic [3:0]   exp_sel;
    int unsigned  key;
    int unsigned  key2;
    logic [31:0]  tmp;
    logic [15:0]  half;
    shortint      zs, ss;
    bit           pass, exp_wr, exp_pix, finished;
    int           rd_cnt, wr_cnt, pix_cnt, ack_cnt, pix_lat, done_at;
    logic [31:0]  rd_adr, wr_adr, wr_dat;
    logic [3:0]   rd_sel, wr_sel;
    logic [15:0]  px, py;
    logic [31:0]  pcol;
    logic [7:0]   pa;
    bit           bus_busy, pix_busy;
    int           bus_dly, pix_dly;

    // Reference model: linear pixel index times two bytes, wrapped to 32 bits.
    lin     = longint'(y) * longint'(w) + longint'(x);
    base_l  = longint'(base);
    exp_adr = 32'(base_l + 2 * lin);
    exp_sel = exp_adr[1] ? 4'b1100 : 4'b0011;
    key     = {2'b00, exp_adr[31:2]};
    if (!mem.exists(key)) mem[key] = $urandom;
    tmp = mem[key];
    if (exp_adr[1]) tmp[31:16] = stored; else tmp[15:0] = stored;
    mem[key] = tmp;
    zs = shortint'(z);
    ss = shortint'(stored);
    pass    = zs > ss;
    exp_wr  = en && pass && UPD;
    exp_pix = !en || pass;

    rd_cnt = 0; wr_cnt = 0; pix_cnt = 0; ack_cnt = 0; pix_lat = 0; done_at = 0;
    rd_adr = 0; wr_adr = 0; wr_dat = 0; rd_sel = 0; wr_sel = 0;
    px = 0; py = 0; pcol = 0; pa = 0;
    bus_busy = 0; pix_busy = 0; bus_dly = 0; pix_dly = 0; finished = 0;

    @(negedge clk_i);
    x_i = x; y_i = y; z_i = z; color_i = col; a_i = a;
    zbuf_enable_i = en; zbuf_base_i = base; target_width_i = w;
    mem_ack_i = 1'b0; ack_i = 1'b0;
    write_i = 1'b1;

    for (int cyc = 1; cyc <= 300 && !finished; cyc++) begin
      @(negedge clk_i);
      if (cyc == 1) begin
        // Accept has happened; configuration changes now must have no effect.
        x_i = 16'($urandom); y_i = 16'($urandom); z_i = 16'($urandom);
        color_i = $urandom; a_i = 8'($urandom);
        zbuf_enable_i = 1'($urandom); zbuf_base_i = $urandom;
        target_width_i = 16'($urandom);
      end
      // downstream sink
      if (write_o) begin
        if (!pix_busy) begin
          pix_busy = 1; pix_cnt++;
          if (pix_cnt == 1) begin
            px = x_o; py = y_o; pcol = color_o; pa = a_o; pix_lat = cyc;
          end
          pix_dly = $urandom_range(0, 3);
        end
        if (pix_dly == 0) begin ack_i = 1'b1; pix_busy = 0; end
        else begin pix_dly--; ack_i = 1'b0; end
      end else begin
        pix_busy = 0; ack_i = 1'($urandom_range(0, 1));
      end
      // depth memory slave
      if (mem_cyc_o && mem_stb_o) begin
        if (!bus_busy) begin
          bus_busy = 1;
          if (mem_we_o) begin
            wr_cnt++; wr_adr = mem_adr_o; wr_sel = mem_sel_o; wr_dat = mem_dat_o;
          end else begin
            rd_cnt++; rd_adr = mem_adr_o; rd_sel = mem_sel_o;
          end
          bus_dly = $urandom_range(0, 3);
        end
        if (bus_dly == 0) begin
          mem_ack_i = 1'b1; bus_busy = 0;
          key2 = {2'b00, mem_adr_o[31:2]};
          if (mem_we_o) begin
            tmp = mem.exists(key2) ? mem[key2] : 32'd0;
            for (int b = 0; b < 4; b++)
              if (mem_sel_o[b]) tmp[b*8 +: 8] = mem_dat_o[b*8 +: 8];
            mem[key2] = tmp;
            mem_dat_i = $urandom;
          end else begin
            mem_dat_i = mem.exists(key2) ? mem[key2] : $urandom;
          end
        end else begin
          bus_dly--; mem_ack_i = 1'b0; mem_dat_i = $urandom;
        end
      end else begin
        bus_busy = 0; mem_ack_i = 1'($urandom_range(0, 1)); mem_dat_i = $urandom;
      end
      // upstream handshake: write_i stays high through the ack_o pulse
      if (ack_o) begin
        ack_cnt++;
        if (done_at == 0) done_at = cyc;
      end
      if (done_at != 0 && cyc == done_at + 1) write_i = 1'b0;
      if (done_at != 0 && cyc == done_at + 6) finished = 1;
    end
    write_i = 1'b0; mem_ack_i = 1'b0; ack_i = 1'b0;

    $display("frag en=%0d x=%0d y=%0d w=%0d adr=%h z=%h stored=%h pass=%0d rd=%0d wr=%0d pix=%0d ack=%0d",
             en, x, y, w, exp_adr, z, stored, pass, rd_cnt, wr_cnt, pix_cnt, ack_cnt);
    check("timeout", finished, 1);
    check("ack_pulses", ack_cnt, 1);
    check("read_count", rd_cnt, en);
    check("write_count", wr_cnt, exp_wr);
    check("pix_count", pix_cnt, exp_pix);
    if (rd_cnt > 0) begin
      check("read_adr", rd_adr, exp_adr);
      check("read_sel", rd_sel, exp_sel);
    end
    if (wr_cnt > 0) begin
      check("write_adr", wr_adr, exp_adr);
      check("write_sel", wr_sel, exp_sel);
      check("write_dat", wr_dat, {z, z});
    end
    if (pix_cnt > 0) begin
      check("x_o", px, x);
      check("y_o", py, y);
      check("color_o", pcol, col);
      check("a_o", pa, a);
      if (!en) check("pix_latency", pix_lat, 1);
    end
    tmp  = mem[key];
    half = exp_adr[1] ? tmp[31:16] : tmp[15:0];
    check("zbuf_content", half, exp_wr ? z : stored);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cyc"}, mem_cyc_o, 0);
    check({tag, "_stb"}, mem_stb_o, 0);
    check({tag, "_we"}, mem_we_o, 0);
    check({tag, "_adr"}, mem_adr_o, 0);
    check({tag, "_write_o"}, write_o, 0);
    check({tag, "_ack_o"}, ack_o, 0);
  endtask

  initial begin
    int acks;
    logic [31:0] b;
    logic [15:0] zr, sr;

    rst_i = 1'b1; write_i = 1'b0; x_i = 0; y_i = 0; z_i = 0; color_i = 0; a_i = 0;
    zbuf_enable_i = 0; zbuf_base_i = 0; target_width_i = 0;
    mem_dat_i = 0; mem_ack_i = 0; ack_i = 0;
    #1;
    check_idle_outputs("reset");
    check("reset_x_o", x_o, 0);
    check("reset_color_o", color_o, 0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    // Test disabled: no bus traffic, pixel one cycle after accept.
    run_frag(1'b0, 32'h0000_2000, 16'd640, 16'd3, 16'd2, 16'h1234, 16'h7FFF, 32'hDEAD_BEEF, 8'h5A);
    // Passing fragment on the upper half-word.
    run_frag(1'b1, 32'h0000_1000, 16'd640, 16'd1, 16'd1, 16'h0020, 16'h0010, 32'h1122_3344, 8'hA5);
    // Equal depth must fail.
    run_frag(1'b1, 32'h0000_1000, 16'd640, 16'd1, 16'd1, 16'h0020, 16'h0020, 32'h5566_7788, 8'h3C);
    // Negative stored depth versus small positive z.
    run_frag(1'b1, 32'h0000_1000, 16'd640, 16'd2, 16'd1, 16'h0001, 16'hFFF0, 32'h0BAD_F00D, 8'h01);

    // Reset in the middle of the depth read.
    @(negedge clk_i);
    x_i = 16'd5; y_i = 16'd7; z_i = 16'h0100; zbuf_enable_i = 1'b1;
    zbuf_base_i = 32'h0000_4000; target_width_i = 16'd100; mem_ack_i = 1'b0;
    write_i = 1'b1;
    for (int i = 0; i < 10 && !mem_cyc_o; i++) @(negedge clk_i);
    check("rst_pre_cyc", mem_cyc_o, 1);
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1 check_idle_outputs("mid_reset");
    write_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      if (ack_o || mem_cyc_o || write_o) acks++;
    end
    check("post_reset_quiet", acks, 0);
    run_frag(1'b1, 32'h0000_4000, 16'd100, 16'd5, 16'd7, 16'h0100, 16'h00FF, 32'hCAFE_0001, 8'h77);

    // Randomized fragments.
    for (int n = 0; n < 40; n++) begin
      b = $urandom; b[0] = 1'b0;
      zr = 16'($urandom);
      sr = ($urandom_range(0, 3) == 0) ? zr : 16'($urandom);
      run_frag(($urandom_range(0, 3) != 0), b, 16'($urandom_range(1, 2048)),
               16'($urandom_range(0, 1023)), 16'($urandom_range(0, 1023)),
               zr, sr, $urandom, 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
